// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP,
      BREAK
   } rx_state_t;

   // Occupancy counter width able to represent 0..depth inclusive.
   function automatic int fn_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; a push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle, otherwise dropped.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic                       full,
   output logic [fn_cnt_w(DEPTH)-1:0] count,
   output logic                       drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = fn_cnt_w(DEPTH);

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty   = (wptr_q == rptr_q);
      full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      drop    = push && !do_push;
      wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = do_pop  ? rptr_q + PW'(1) : rptr_q;
   end

   assign count = CW'(wptr_q - rptr_q);
   assign dout  = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width/parity) feeding a FWFT receive FIFO,
// with sticky overrun / framing / parity error flags.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on rxs
// START | half-bit wait, confirm start bit still low
// DATA  | sample DATA_BITS data bits, LSB first, one per bit period
// PAR   | sample parity bit and record mismatch
// STOP  | sample stop bit; push, or flag parity/framing error
// BREAK | line stuck low after a framing error, wait for release
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 86,
   parameter int DATA_BITS        = 8,
   parameter int PARITY           = 0,
   parameter int DEPTH            = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       rxd,
   input  logic                       rd_en,
   output logic [DATA_BITS-1:0]       dout,
   output logic                       empty,
   output logic                       full,
   output logic [fn_cnt_w(DEPTH)-1:0] count,
   input  logic                       err_clr,
   output logic                       overrun,
   output logic                       frame_err,
   output logic                       parity_err
);

   localparam int             TW       = $clog2(2 * CLK_PER_HALF_BIT);
   localparam logic [TW-1:0]  HALF_LD  = TW'(CLK_PER_HALF_BIT - 1);
   localparam logic [TW-1:0]  FULL_LD  = TW'(2 * CLK_PER_HALF_BIT - 1);
   localparam parity_t        PAR_MODE = parity_t'(PARITY);
   localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);

   rx_state_t            state_q, state_d;
   logic                 rx_meta_q, rxs_q;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bad_q, par_bad_d;
   logic                 overrun_q, overrun_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 tc;
   logic                 push;
   logic                 drop;
   logic                 set_fe;
   logic                 set_pe;

   assign tc = (tmr_q == '0);

   always_comb begin
      state_d   = state_q;
      tmr_d     = tc ? tmr_q : tmr_q - TW'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      push      = 1'b0;
      set_fe    = 1'b0;
      set_pe    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rxs_q) begin
               tmr_d   = HALF_LD;
               state_d = START;
            end
         end
         START: begin
            if (tc) begin
               if (rxs_q) begin
                  state_d = IDLE;
               end else begin
                  tmr_d     = FULL_LD;
                  bit_cnt_d = '0;
                  par_bad_d = 1'b0;
                  state_d   = DATA;
               end
            end
         end
         DATA: begin
            if (tc) begin
               shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
               tmr_d     = FULL_LD;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LAST_BIT) state_d = (PAR_MODE == PAR_NONE) ? STOP : PAR;
            end
         end
         PAR: begin
            if (tc) begin
               // even: data XOR parity must be 0; odd: must be 1
               par_bad_d = ((^shift_q) ^ rxs_q) != (PAR_MODE == PAR_ODD);
               tmr_d     = FULL_LD;
               state_d   = STOP;
            end
         end
         STOP: begin
            if (tc) begin
               if (!rxs_q) begin
                  set_fe  = 1'b1;
                  state_d = BREAK;
               end else begin
                  if (par_bad_q) set_pe = 1'b1;
                  else           push   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         BREAK: begin
            if (rxs_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      overrun_d    = drop   ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
      frame_err_d  = set_fe ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
      parity_err_d = set_pe ? 1'b1 : (err_clr ? 1'b0 : parity_err_q);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         rx_meta_q    <= 1'b1;
         rxs_q        <= 1'b1;
         tmr_q        <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_bad_q    <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_meta_q    <= rxd;
         rxs_q        <= rx_meta_q;
         tmr_q        <= tmr_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_bad_q    <= par_bad_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (rd_en),
      .din   (shift_q),
      .dout  (dout),
      .empty (empty),
      .full  (full),
      .count (count),
      .drop  (drop)
   );

endmodule
